// File: rtl/bus_arbiter.sv
// Two-master (instruction/data) AHB-lite style arbiter sharing one slave port.
// Define BUS_ARB_RR_EN for round-robin arbitration; default is fixed priority, data over instruction.
module bus_arbiter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_haddr,
    input  logic [31:0] d_haddr,
    input  logic        i_hprot,
    input  logic        d_hprot,
    input  logic [1:0]  i_hsize,
    input  logic [1:0]  d_hsize,
    input  logic        d_hwrite,
    input  logic [31:0] i_hwdata,
    input  logic [31:0] d_hwdata,
    input  logic        i_htrans,
    input  logic        d_htrans,
    output logic [31:0] i_hrdata,
    output logic [31:0] d_hrdata,
    output logic        i_hresp,
    output logic        d_hresp,
    output logic        i_hready,
    output logic        d_hready,
    output logic [31:0] haddr,
    output logic        hprot,
    output logic [1:0]  hsize,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic        htrans,
    input  logic [31:0] hrdata,
    input  logic        hresp,
    input  logic        hready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DATA = 2'd2
    } mstate_t;

    mstate_t     i_state;
    mstate_t     d_state;
    logic [31:0] i_pend_addr;
    logic [31:0] d_pend_addr;
    logic        i_pend_prot;
    logic        d_pend_prot;
    logic [1:0]  i_pend_size;
    logic [1:0]  d_pend_size;
    logic        d_pend_write;
    logic        req_i;
    logic        req_d;
    logic        gnt_i;
    logic        gnt_d;
`ifdef BUS_ARB_RR_EN
    logic        rr_last;
`endif

    // A pending master keeps requesting regardless of what it drives live.
    assign req_i = (i_state == PEND) || i_htrans;
    assign req_d = (d_state == PEND) || d_htrans;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (hready) begin
`ifdef BUS_ARB_RR_EN
            if (req_i && req_d) begin
                gnt_d = !rr_last;
                gnt_i = rr_last;
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
`else
            gnt_d = req_d;
            gnt_i = req_i && !req_d;
`endif
        end
    end

    always_comb begin
        haddr  = 32'h0;
        hprot  = 1'b0;
        hsize  = 2'b00;
        hwrite = 1'b0;
        htrans = 1'b0;
        if (gnt_d) begin
            htrans = 1'b1;
            if (d_state == PEND) begin
                haddr  = d_pend_addr;
                hprot  = d_pend_prot;
                hsize  = d_pend_size;
                hwrite = d_pend_write;
            end else begin
                haddr  = d_haddr;
                hprot  = d_hprot;
                hsize  = d_hsize;
                hwrite = d_hwrite;
            end
        end else if (gnt_i) begin
            htrans = 1'b1;
            if (i_state == PEND) begin
                haddr = i_pend_addr;
                hprot = i_pend_prot;
                hsize = i_pend_size;
            end else begin
                haddr = i_haddr;
                hprot = i_hprot;
                hsize = i_hsize;
            end
        end
    end

    always_comb begin
        hwdata = 32'h0;
        if (d_state == DATA) begin
            hwdata = d_hwdata;
        end else if (i_state == DATA) begin
            hwdata = i_hwdata;
        end
    end

    assign i_hrdata = hrdata;
    assign d_hrdata = hrdata;
    assign i_hresp  = (i_state == DATA) && hresp;
    assign d_hresp  = (d_state == DATA) && hresp;

    // A master that presents an address it has not been granted is stalled.
    always_comb begin
        i_hready = 1'b1;
        if (i_state == DATA) begin
            i_hready = hready;
        end else if (i_state == PEND) begin
            i_hready = 1'b0;
        end else if (i_htrans && !gnt_i) begin
            i_hready = 1'b0;
        end
    end

    always_comb begin
        d_hready = 1'b1;
        if (d_state == DATA) begin
            d_hready = hready;
        end else if (d_state == PEND) begin
            d_hready = 1'b0;
        end else if (d_htrans && !gnt_d) begin
            d_hready = 1'b0;
        end
    end

    // Everything advances only on slave ready, so error and wait cycles freeze the arbiter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_state      <= IDLE;
            d_state      <= IDLE;
            i_pend_addr  <= 32'h0;
            d_pend_addr  <= 32'h0;
            i_pend_prot  <= 1'b0;
            d_pend_prot  <= 1'b0;
            i_pend_size  <= 2'b00;
            d_pend_size  <= 2'b00;
            d_pend_write <= 1'b0;
`ifdef BUS_ARB_RR_EN
            rr_last      <= 1'b0;
`endif
        end else if (hready) begin
            if (gnt_i) begin
                i_state <= DATA;
            end else if (i_state == DATA) begin
                if (i_htrans) begin
                    i_state     <= PEND;
                    i_pend_addr <= i_haddr;
                    i_pend_prot <= i_hprot;
                    i_pend_size <= i_hsize;
                end else begin
                    i_state <= IDLE;
                end
            end

            if (gnt_d) begin
                d_state <= DATA;
            end else if (d_state == DATA) begin
                if (d_htrans) begin
                    d_state      <= PEND;
                    d_pend_addr  <= d_haddr;
                    d_pend_prot  <= d_hprot;
                    d_pend_size  <= d_hsize;
                    d_pend_write <= d_hwrite;
                end else begin
                    d_state <= IDLE;
                end
            end

`ifdef BUS_ARB_RR_EN
            if (gnt_i) begin
                rr_last <= 1'b0;
            end else if (gnt_d) begin
                rr_last <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter: per-cycle vectors plus a mid-transfer reset sequence.
// Expected values follow the fixed-priority build, or round-robin when BUS_ARB_RR_EN is defined.
module tb_bus_arbiter;

    localparam logic [31:0] IWD = 32'h1111_1111;

    logic        clk;
    logic        rstn;
    logic [31:0] i_haddr;
    logic [31:0] d_haddr;
    logic        i_hprot;
    logic        d_hprot;
    logic [1:0]  i_hsize;
    logic [1:0]  d_hsize;
    logic        d_hwrite;
    logic [31:0] i_hwdata;
    logic [31:0] d_hwdata;
    logic        i_htrans;
    logic        d_htrans;
    logic [31:0] i_hrdata;
    logic [31:0] d_hrdata;
    logic        i_hresp;
    logic        d_hresp;
    logic        i_hready;
    logic        d_hready;
    logic [31:0] haddr;
    logic        hprot;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        htrans;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;

    int n_total = 0;
    int n_pass  = 0;

    bus_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_haddr  (i_haddr),
        .d_haddr  (d_haddr),
        .i_hprot  (i_hprot),
        .d_hprot  (d_hprot),
        .i_hsize  (i_hsize),
        .d_hsize  (d_hsize),
        .d_hwrite (d_hwrite),
        .i_hwdata (i_hwdata),
        .d_hwdata (d_hwdata),
        .i_htrans (i_htrans),
        .d_htrans (d_htrans),
        .i_hrdata (i_hrdata),
        .d_hrdata (d_hrdata),
        .i_hresp  (i_hresp),
        .d_hresp  (d_hresp),
        .i_hready (i_hready),
        .d_hready (d_hready),
        .haddr    (haddr),
        .hprot    (hprot),
        .hsize    (hsize),
        .hwrite   (hwrite),
        .hwdata   (hwdata),
        .htrans   (htrans),
        .hrdata   (hrdata),
        .hresp    (hresp),
        .hready   (hready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // own: 0 = no grant, 1 = instruction master granted, 2 = data master granted
    typedef struct {
        string       name;
        logic        it;
        logic [31:0] ia;
        logic        dt;
        logic [31:0] da;
        logic        dw;
        logic [31:0] dwd;
        logic        rdy;
        logic        rsp;
        int          own;
        logic [31:0] ea;
        logic        ewr;
        logic [31:0] ewd;
        logic        eir;
        logic        edr;
        logic        eie;
        logic        ede;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic it, input logic [31:0] ia,
                       input logic dt, input logic [31:0] da, input logic dw,
                       input logic [31:0] dwd, input logic rdy, input logic rsp,
                       input int own, input logic [31:0] ea, input logic ewr,
                       input logic [31:0] ewd, input logic eir, input logic edr,
                       input logic eie, input logic ede);
        vec_t v;
        v.name = n; v.it = it; v.ia = ia; v.dt = dt; v.da = da; v.dw = dw;
        v.dwd = dwd; v.rdy = rdy; v.rsp = rsp; v.own = own; v.ea = ea;
        v.ewr = ewr; v.ewd = ewd; v.eir = eir; v.edr = edr; v.eie = eie; v.ede = ede;
        vecs.push_back(v);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        i_htrans = v.it;
        i_haddr  = v.ia;
        d_htrans = v.dt;
        d_haddr  = v.da;
        d_hwrite = v.dw;
        d_hwdata = v.dwd;
        hready   = v.rdy;
        hresp    = v.rsp;
        hrdata   = 32'hA000_0000 + 32'(idx);
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check_val({v.name, ".htrans"}, 32'(htrans), 32'(v.own != 0));
        if (v.own != 0) begin
            check_val({v.name, ".haddr"}, haddr, v.ea);
            check_val({v.name, ".hwrite"}, 32'(hwrite), 32'(v.ewr));
            check_val({v.name, ".hprot"}, 32'(hprot), (v.own == 2) ? 32'd1 : 32'd0);
            check_val({v.name, ".hsize"}, 32'(hsize), (v.own == 2) ? 32'd1 : 32'd2);
        end
        check_val({v.name, ".hwdata"}, hwdata, v.ewd);
        check_val({v.name, ".i_hready"}, 32'(i_hready), 32'(v.eir));
        check_val({v.name, ".d_hready"}, 32'(d_hready), 32'(v.edr));
        check_val({v.name, ".i_hresp"}, 32'(i_hresp), 32'(v.eie));
        check_val({v.name, ".d_hresp"}, 32'(d_hresp), 32'(v.ede));
        check_val({v.name, ".i_hrdata"}, i_hrdata, 32'hA000_0000 + 32'(idx));
        check_val({v.name, ".d_hrdata"}, d_hrdata, 32'hA000_0000 + 32'(idx));
    endtask

    initial begin
        rstn = 1'b0;
        i_haddr = 32'h0; d_haddr = 32'h0; i_hprot = 1'b0; d_hprot = 1'b1;
        i_hsize = 2'b10; d_hsize = 2'b01; d_hwrite = 1'b0;
        i_hwdata = IWD; d_hwdata = 32'h0; i_htrans = 1'b0; d_htrans = 1'b0;
        hrdata = 32'h0; hresp = 1'b1; hready = 1'b1;

        //  name             it ia            dt da       dw dwd            rdy rsp own ea       wr wdata          ir dr ie de
        add("reset_idle",    0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 0,  0, 32'h0,   0, 32'h0,         1, 1, 0, 0);
        add("fetch0",        1, 32'h40,       0, 32'h0,   0, 32'h0,         1, 0,  1, 32'h40,  0, 32'h0,         1, 1, 0, 0);
        add("fetch1",        1, 32'h44,       0, 32'h0,   0, 32'h0,         1, 0,  1, 32'h44,  0, IWD,           1, 1, 0, 0);
        add("fetch2",        1, 32'h48,       0, 32'h0,   0, 32'h0,         1, 0,  1, 32'h48,  0, IWD,           1, 1, 0, 0);
        add("fetch_end",     0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 0,  0, 32'h0,   0, IWD,           1, 1, 0, 0);
        add("idle",          0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 0,  0, 32'h0,   0, 32'h0,         1, 1, 0, 0);
        add("d_read",        0, 32'h0,        1, 32'h200, 0, 32'hDDDD_0006, 1, 0,  2, 32'h200, 0, 32'h0,         1, 1, 0, 0);
        add("d_read_data",   0, 32'h0,        0, 32'h0,   0, 32'hDDDD_0007, 1, 0,  0, 32'h0,   0, 32'hDDDD_0007, 1, 1, 0, 0);
`ifdef BUS_ARB_RR_EN
        add("contend",       1, 32'h40,       1, 32'h100, 1, 32'h0,         1, 0,  1, 32'h40,  0, 32'h0,         1, 0, 0, 0);
        add("contend_d",     0, 32'h0,        1, 32'h100, 1, 32'h0,         1, 0,  2, 32'h100, 1, IWD,           1, 1, 0, 0);
        add("contend_data",  0, 32'h0,        0, 32'h0,   0, 32'hCAFE_0001, 1, 0,  0, 32'h0,   0, 32'hCAFE_0001, 1, 1, 0, 0);
`else
        add("contend",       1, 32'h40,       1, 32'h100, 1, 32'h0,         1, 0,  2, 32'h100, 1, 32'h0,         0, 1, 0, 0);
        add("contend_i",     1, 32'h40,       0, 32'h0,   0, 32'hCAFE_0001, 1, 0,  1, 32'h40,  0, 32'hCAFE_0001, 1, 1, 0, 0);
        add("contend_data",  0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 0,  0, 32'h0,   0, IWD,           1, 1, 0, 0);
`endif
        add("i_fetch",       1, 32'h40,       0, 32'h0,   0, 32'h0,         1, 0,  1, 32'h40,  0, 32'h0,         1, 1, 0, 0);
        add("i_overlap",     1, 32'h44,       1, 32'h100, 0, 32'h0,         1, 0,  2, 32'h100, 0, IWD,           1, 1, 0, 0);
        add("i_pend",        0, 32'hDEAD_0000,0, 32'h0,   0, 32'hDDDD_0013, 1, 0,  1, 32'h44,  0, 32'hDDDD_0013, 0, 1, 0, 0);
        add("i_pend_data",   0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 0,  0, 32'h0,   0, IWD,           1, 1, 0, 0);
        add("err_fetch",     1, 32'h80,       0, 32'h0,   0, 32'h0,         1, 0,  1, 32'h80,  0, 32'h0,         1, 1, 0, 0);
        add("err_cycle1",    1, 32'h84,       1, 32'h100, 0, 32'h0,         0, 1,  0, 32'h0,   0, IWD,           0, 0, 1, 0);
        add("err_cycle2",    0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 1,  0, 32'h0,   0, IWD,           1, 1, 1, 0);
        add("idle_resp",     0, 32'h0,        0, 32'h0,   0, 32'h0,         1, 1,  0, 32'h0,   0, 32'h0,         1, 1, 0, 0);

        // Held in reset with a slave error asserted: outputs must show an idle bus.
        #12;
        check_val("rst.htrans", 32'(htrans), 32'd0);
        check_val("rst.hwdata", hwdata, 32'h0);
        check_val("rst.i_hready", 32'(i_hready), 32'd1);
        check_val("rst.d_hready", 32'(d_hready), 32'd1);
        check_val("rst.i_hresp", 32'(i_hresp), 32'd0);
        check_val("rst.d_hresp", 32'(d_hresp), 32'd0);
        @(negedge clk);
        rstn  = 1'b1;
        hresp = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[k], k);
            @(negedge clk);
            check_output(vecs[k], k);
        end

        // Reset pulsed while the data master owns the data phase.
        @(posedge clk);
        #1;
        i_htrans = 1'b0; d_htrans = 1'b1; d_haddr = 32'h300; d_hwrite = 1'b1;
        hready = 1'b1; hresp = 1'b0;
        @(negedge clk);
        check_val("mid.grant_htrans", 32'(htrans), 32'd1);
        check_val("mid.grant_haddr", haddr, 32'h300);
        @(posedge clk);
        #1;
        d_htrans = 1'b0; d_hwdata = 32'hBEEF_0001; hresp = 1'b1;
        @(negedge clk);
        check_val("mid.data_hwdata", hwdata, 32'hBEEF_0001);
        check_val("mid.data_d_hresp", 32'(d_hresp), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("mid.rst_hwdata", hwdata, 32'h0);
        check_val("mid.rst_d_hresp", 32'(d_hresp), 32'd0);
        check_val("mid.rst_htrans", 32'(htrans), 32'd0);
        check_val("mid.rst_d_hready", 32'(d_hready), 32'd1);
        check_val("mid.rst_i_hready", 32'(i_hready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1; hresp = 1'b0;
        @(negedge clk);
        check_val("post.hwdata", hwdata, 32'h0);
        check_val("post.htrans", 32'(htrans), 32'd0);
        @(posedge clk);
        #1;
        i_htrans = 1'b1; i_haddr = 32'h40;
        @(negedge clk);
        check_val("post.fetch_htrans", 32'(htrans), 32'd1);
        check_val("post.fetch_haddr", haddr, 32'h40);
        check_val("post.fetch_i_hready", 32'(i_hready), 32'd1);
        @(posedge clk);
        #1;
        i_htrans = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
